// File: rtl/julia_pkg.sv
// Shared types, default widths and escape-threshold helper for the Julia-set iteration engine.
package julia_pkg;

  localparam int W_DEF      = 32;
  localparam int FRAC_DEF   = 16;
  localparam int ITER_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    UPD,
    DONE
  } state_t;

  // Squared radius moved into the product domain, which carries 2*FRAC fractional bits.
  function automatic logic [2*W_DEF:0] esc_thresh(input int esc_r2, input int frac);
    logic [2*W_DEF:0] t;
    t = (2*W_DEF+1)'(esc_r2) << (2 * frac);
    return t;
  endfunction

endpackage

// File: rtl/julia_mul_stage.sv
// Registered full-precision squares and cross product of the current z, loaded once per iteration.
module julia_mul_stage
#(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic signed [W-1:0]   zx,
  input  logic signed [W-1:0]   zy,
  output logic signed [2*W-1:0] xx,
  output logic signed [2*W-1:0] yy,
  output logic signed [2*W-1:0] xy
);

  logic signed [2*W-1:0] zx_e;
  logic signed [2*W-1:0] zy_e;

  assign zx_e = {{W{zx[W-1]}}, zx};
  assign zy_e = {{W{zy[W-1]}}, zy};

  always_ff @(posedge clk) begin
    if (rst) begin
      xx <= '0;
      yy <= '0;
      xy <= '0;
    end else if (load) begin
      xx <= zx_e * zx_e;
      yy <= zy_e * zy_e;
      xy <= zx_e * zy_e;
    end
  end

endmodule

// File: rtl/julia_iter_engine.sv
// Fixed-point Julia-set iterator: z <- z^2 + c until escape or MAX_ITER, two cycles per iteration.
//   state | meaning
//   IDLE  | in_ready high, waiting for a job
//   MUL   | products of current z being registered
//   UPD   | escape / limit test, else z and iter update
//   DONE  | result presented until out_ready
module julia_iter_engine
  import julia_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int ITER_W   = ITER_W_DEF,
  parameter int MAX_ITER = 255,
  parameter int ESC_R2   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_x,
  input  logic signed [W-1:0] in_y,
  input  logic signed [W-1:0] cr,
  input  logic signed [W-1:0] ci,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ITER_W-1:0]   out_iter,
  output logic                out_escaped,
  output logic signed [W-1:0] out_wx,
  output logic signed [W-1:0] out_wy
);

  localparam logic [2*W:0] ESC_TH = (2*W+1)'(esc_thresh(ESC_R2, FRAC));

  state_t                state;
  logic signed [W-1:0]   zx, zy, cr_r, ci_r;
  logic [ITER_W-1:0]     iter;
  logic signed [2*W-1:0] xx, yy, xy;
  logic [2*W:0]          mag;
  logic                  escape;
  logic                  at_limit;
  logic signed [2*W-1:0] re_full, im_full;
  logic signed [W-1:0]   zx_nxt, zy_nxt;

  julia_mul_stage #(.W(W)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (state == MUL),
    .zx   (zx),
    .zy   (zy),
    .xx   (xx),
    .yy   (yy),
    .xy   (xy)
  );

  // Squares are never negative, so zero-extension keeps the sum exact.
  assign mag      = {1'b0, xx} + {1'b0, yy};
  assign escape   = mag > ESC_TH;
  assign at_limit = iter == ITER_W'(MAX_ITER);
  assign re_full  = (xx - yy) >>> FRAC;
  assign im_full  = (xy <<< 1) >>> FRAC;
  assign zx_nxt   = re_full[W-1:0] + cr_r;
  assign zy_nxt   = im_full[W-1:0] + ci_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
      out_wx      <= '0;
      out_wy      <= '0;
      zx          <= '0;
      zy          <= '0;
      cr_r        <= '0;
      ci_r        <= '0;
      iter        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            zx       <= in_x;
            zy       <= in_y;
            cr_r     <= cr;
            ci_r     <= ci;
            iter     <= '0;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: state <= UPD;
        UPD: begin
          // Escape is tested on z before the update, so z and iter are reported as-is.
          if (escape || at_limit) begin
            out_valid   <= 1'b1;
            out_escaped <= escape;
            out_iter    <= iter;
            out_wx      <= zx;
            out_wy      <= zy;
            state       <= DONE;
          end else begin
            zx    <= zx_nxt;
            zy    <= zy_nxt;
            iter  <= iter + 1'b1;
            state <= MUL;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_iter_engine.sv
// Scoreboard bench for julia_iter_engine: directed cases plus randomized jobs against a behavioural model.
module tb_julia_iter_engine;

  localparam int MAXI = 255;

  typedef struct {
    logic [7:0]  it;
    logic        esc;
    logic [31:0] wx;
    logic [31:0] wy;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0, in_y = '0, cr = '0, ci = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_iter;
  logic        out_escaped;
  logic [31:0] out_wx, out_wy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   bp_en = 1'b0;
  bit   or_force = 1'b1;
  bit   prev_v = 1'b0;
  exp_t sb[$];

  julia_iter_engine #(
    .W(32), .FRAC(16), .ITER_W(8), .MAX_ITER(MAXI), .ESC_R2(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .cr          (cr),
    .ci          (ci),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_escaped (out_escaped),
    .out_wx      (out_wx),
    .out_wy      (out_wy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? ($urandom_range(0, 3) != 0) : or_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int it, input bit esc, input int wx, input int wy);
    exp_t e;
    e.it = 8'(it); e.esc = esc; e.wx = wx; e.wy = wy; e.acc = 0;
    return e;
  endfunction

  // Reference: iterate the complex recurrence directly with wide integer arithmetic.
  function automatic exp_t model(input int x, input int y, input int a, input int b);
    int                  zx, zy;
    longint              xx, yy, xy;
    logic signed [127:0] m, th;
    exp_t                e;
    zx = x; zy = y;
    th = 128'sd4 <<< 32;
    e = mk(0, 1'b0, 0, 0);
    for (int k = 0; k <= MAXI; k++) begin
      xx = longint'(zx) * longint'(zx);
      yy = longint'(zy) * longint'(zy);
      xy = longint'(zx) * longint'(zy);
      m  = xx;
      m  = m + yy;
      if (m > th) return mk(k, 1'b1, zx, zy);
      if (k == MAXI) return mk(k, 1'b0, zx, zy);
      zx = int'((xx - yy) >>> 16) + a;
      zy = int'((2 * xy) >>> 16) + b;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          if (!prev_v) chk("latency", cyc - sb[0].acc, 2 * (sb[0].it + 1));
          chk("out_iter", out_iter, sb[0].it);
          chk("out_escaped", out_escaped, sb[0].esc);
          chk("out_wx", out_wx, sb[0].wx);
          chk("out_wy", out_wy, sb[0].wy);
          chk("in_ready_busy", in_ready, 0);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_v = out_valid;
    end
  end

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!in_ready && n < budget) begin @(negedge clk); n++; end
    if (!in_ready) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin @(negedge clk); n++; end
    if (!out_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic wait_not_valid(input int budget);
    int n = 0;
    while (out_valid && n < budget) begin @(negedge clk); n++; end
    if (out_valid) chk("wait_release_timeout", 1, 0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic send(input int x, input int y, input int a, input int b, input exp_t e);
    exp_t ee;
    wait_ready(3000);
    in_x = x; in_y = y; cr = a; ci = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ee = e;
    ee.acc = cyc;
    sb.push_back(ee);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x, y, a, b;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_iter", out_iter, 0);
    chk("rst_out_wx", out_wx, 0);
    rst = 1'b0;
    @(negedge clk);

    send(0, 0, 0, 0, mk(255, 1'b0, 0, 0));
    wait_drain(1000);
    send(196608, 0, 0, 0, mk(0, 1'b1, 196608, 0));
    wait_drain(100);
    send(65536, 0, 65536, 0, mk(2, 1'b1, 327680, 0));
    wait_drain(100);
    send(0, 0, -131072, 0, mk(255, 1'b0, 131072, 0));
    wait_drain(1000);

    // Back-pressure with in_valid pulsing while the result is held.
    or_force = 1'b0;
    send(65536, 0, 65536, 0, mk(2, 1'b1, 327680, 0));
    wait_valid(100);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_x = $urandom; in_y = $urandom;
      chk("bp_held_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    or_force = 1'b1;
    wait_not_valid(20);
    chk("bp_back_idle", in_ready, 1);
    repeat (6) @(negedge clk);
    chk("bp_no_phantom", out_valid, 0);
    wait_drain(20);

    // Reset in the middle of a long job.
    send(0, 0, 0, 0, mk(255, 1'b0, 0, 0));
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_iter", out_iter, 0);
    chk("midrst_out_escaped", out_escaped, 0);
    chk("midrst_out_wx", out_wx, 0);
    chk("midrst_out_wy", out_wy, 0);
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    send(65536, 0, 65536, 0, mk(2, 1'b1, 327680, 0));
    wait_drain(100);

    bp_en = 1'b1;
    for (int j = 0; j < 24; j++) begin
      if (j % 6 == 5) begin
        x = $urandom; y = $urandom; a = $urandom; b = $urandom;
      end else begin
        x = int'($urandom_range(0, 262144)) - 131072;
        y = int'($urandom_range(0, 262144)) - 131072;
        a = int'($urandom_range(0, 131072)) - 65536;
        b = int'($urandom_range(0, 131072)) - 65536;
      end
      send(x, y, a, b, model(x, y, a, b));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain(3000);
    bp_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
